// File: rtl/clock_rate_generator_pkg.sv
// Shared types for the I/O clock rate generator.
// Clock-domain bundle plus rate configuration and FSM state types.
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

package clks_alot_p;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    typedef struct packed {
        logic [COUNT_W-1:0] half_target;
        logic [COUNT_W-1:0] quarter_target;
    } rate_cfg_s;

    // A zero target would never wrap, so it is treated as one.
    function automatic logic [COUNT_W-1:0] clamp1(
        input logic [COUNT_W-1:0] v
    );
        logic [COUNT_W-1:0] one;
        one = {{(COUNT_W-1){1'b0}}, 1'b1};
        return (v == '0) ? one : v;
    endfunction

endpackage

// File: rtl/clock_rate_generator_counter.sv
// Half-period rate counter with shadowed targets.
// Strobes are registered from the next-cycle counter value.
module rate_counter
    import clks_alot_p::*;
#(
    parameter int COUNT_W = clks_alot_p::COUNT_W
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_run,
    input  logic      i_start,
    input  rate_cfg_s i_cfg,
    output logic      o_half,
    output logic      o_quarter
);

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] w_cnt_nxt;
    rate_cfg_s          r_cfg;
    rate_cfg_s          w_cfg_nxt;
    logic               w_wrap;
    logic               w_half_nxt;
    logic               w_qtr_nxt;

    assign w_wrap = (r_cnt == (r_cfg.half_target - ONE));

    always_comb begin
        w_cnt_nxt = r_cnt + ONE;
        w_cfg_nxt = r_cfg;
        if (!i_run) begin
            w_cnt_nxt = '0;
        end else if (i_start || w_wrap) begin
            w_cnt_nxt = '0;
            w_cfg_nxt.half_target    = clamp1(i_cfg.half_target);
            w_cfg_nxt.quarter_target = clamp1(i_cfg.quarter_target);
        end
    end

    always_comb begin
        w_half_nxt = i_run &&
            (w_cnt_nxt == (w_cfg_nxt.half_target - ONE));
        // Quarter point only exists strictly inside the half-period.
        w_qtr_nxt = i_run &&
            (w_cfg_nxt.quarter_target < w_cfg_nxt.half_target) &&
            (w_cnt_nxt == (w_cfg_nxt.quarter_target - ONE));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt                <= '0;
            r_cfg.half_target    <= ONE;
            r_cfg.quarter_target <= ONE;
            o_half               <= 1'b0;
            o_quarter            <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_cfg     <= w_cfg_nxt;
            o_half    <= w_half_nxt;
            o_quarter <= w_qtr_nxt;
        end
    end

endmodule

// File: rtl/clock_rate_generator.sv
// Divided I/O clock generator with start/run/stop sequencing.
// io_clk always parks at the idle level sampled before start.
module clock_rate_generator
    import common_p::*;
    import clks_alot_p::*;
#(
    parameter int COUNT_W = clks_alot_p::COUNT_W
) (
    input  clk_dom_s           sys_dom_i,
    input  logic               clock_enable_i,
    input  logic               idle_level_i,
    input  logic [COUNT_W-1:0] half_rate_target_i,
    input  logic [COUNT_W-1:0] quarter_rate_target_i,
    output logic               io_clk_o,
    output logic               half_rate_elapsed_o,
    output logic               quarter_rate_elapsed_o,
    output logic               clock_active_o
);

    logic      w_clk;
    logic      w_rst_n;
    state_e    r_state;
    logic      r_idle_lvl;
    rate_cfg_s w_cfg;
    logic      w_half;
    logic      w_qtr;
    logic      w_bound;
    logic      w_new_lvl;
    logic      w_start;
    logic      w_park;
    logic      w_run_nxt;

    assign w_clk   = sys_dom_i.clk;
    assign w_rst_n = sys_dom_i.rst_n;

    assign w_cfg = '{
        half_target:    half_rate_target_i,
        quarter_target: quarter_rate_target_i
    };

    assign w_bound   = w_half && (r_state != IDLE);
    assign w_new_lvl = ~io_clk_o;
    assign w_start   = (r_state == IDLE) && clock_enable_i;
    assign w_park    = (r_state == STOP) && w_bound &&
                       !clock_enable_i && (w_new_lvl == r_idle_lvl);
    assign w_run_nxt = (r_state == IDLE) ? clock_enable_i : !w_park;

    rate_counter #(
        .COUNT_W (COUNT_W)
    ) u_rate_counter (
        .i_clk     (w_clk),
        .i_rst_n   (w_rst_n),
        .i_run     (w_run_nxt),
        .i_start   (w_start),
        .i_cfg     (w_cfg),
        .o_half    (w_half),
        .o_quarter (w_qtr)
    );

    assign half_rate_elapsed_o    = w_half;
    assign quarter_rate_elapsed_o = w_qtr;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= IDLE;
            r_idle_lvl     <= 1'b0;
            io_clk_o       <= 1'b0;
            clock_active_o <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    io_clk_o   <= idle_level_i;
                    r_idle_lvl <= idle_level_i;
                    if (clock_enable_i) begin
                        r_state        <= RUN;
                        clock_active_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_bound) begin
                        io_clk_o <= w_new_lvl;
                    end
                    if (!clock_enable_i) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // Decisions are taken only at a half boundary.
                    if (w_bound) begin
                        io_clk_o <= w_new_lvl;
                        if (clock_enable_i) begin
                            r_state <= RUN;
                        end else if (w_park) begin
                            r_state        <= IDLE;
                            clock_active_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    clock_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_rate_generator.sv
// Directed bench for clock_rate_generator.
// Cycle model feeds a scoreboard; directed counts cover the scenarios.
module tb_clock_rate_generator;
    import common_p::*;
    import clks_alot_p::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        idl = 1'b0;
    logic [15:0] ht = 16'd4;
    logic [15:0] qt = 16'd2;
    clk_dom_s    dom;

    logic io_clk;
    logic half;
    logic qtr;
    logic act;

    assign dom = '{clk: clk, rst_n: rst_n};

    always #5 clk = ~clk;

    clock_rate_generator #(
        .COUNT_W (16)
    ) dut (
        .sys_dom_i              (dom),
        .clock_enable_i         (en),
        .idle_level_i           (idl),
        .half_rate_target_i     (ht),
        .quarter_rate_target_i  (qt),
        .io_clk_o               (io_clk),
        .half_rate_elapsed_o    (half),
        .quarter_rate_elapsed_o (qtr),
        .clock_active_o         (act)
    );

    typedef struct packed {
        logic io;
        logic hf;
        logic qr;
        logic ac;
    } obs_t;

    obs_t sb[$];

    state_e      m_st;
    logic [15:0] m_cnt;
    logic [15:0] m_h;
    logic [15:0] m_q;
    logic        m_clk;
    logic        m_idle;

    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   c_half;
    int   c_qtr;
    int   c_act;
    int   c_tog;
    logic prev_io = 1'b0;
    logic half_last = 1'b0;
    logic half_prev = 1'b0;
    int   n;

    function automatic logic [15:0] max1(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.ac = (m_st != IDLE);
        o.io = m_clk;
        o.hf = o.ac && (m_cnt == m_h - 16'd1);
        o.qr = o.ac && (m_q < m_h) && (m_cnt == m_q - 16'd1);
        return o;
    endfunction

    task automatic model_reset();
        m_st   = IDLE;
        m_cnt  = 16'd0;
        m_h    = 16'd1;
        m_q    = 16'd1;
        m_clk  = 1'b0;
        m_idle = 1'b0;
    endtask

    task automatic model_step();
        obs_t cur;
        logic nl;
        cur = model_out();
        if (!rst_n) begin
            model_reset();
        end else if (m_st == IDLE) begin
            m_clk = idl;
            m_cnt = 16'd0;
            if (en) begin
                m_st   = RUN;
                m_idle = idl;
                m_h    = max1(ht);
                m_q    = max1(qt);
            end
        end else if (cur.hf) begin
            nl    = ~m_clk;
            m_clk = nl;
            m_cnt = 16'd0;
            m_h   = max1(ht);
            m_q   = max1(qt);
            if (m_st == RUN) begin
                if (!en) m_st = STOP;
            end else if (en) begin
                m_st = RUN;
            end else if (nl == m_idle) begin
                m_st = IDLE;
            end
        end else begin
            m_cnt = m_cnt + 16'd1;
            if (m_st == RUN && !en) m_st = STOP;
        end
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        c_half = 0;
        c_qtr  = 0;
        c_act  = 0;
        c_tog  = 0;
    endtask

    task automatic tick();
        obs_t e;
        @(posedge clk);
        model_step();
        sb.push_back(model_out());
        #1;
        e = sb.pop_front();
        check("io_clk", io_clk, e.io);
        check("half", half, e.hf);
        check("quarter", qtr, e.qr);
        check("active", act, e.ac);
        c_half += int'(half);
        c_qtr  += int'(qtr);
        c_act  += int'(act);
        if (io_clk !== prev_io) c_tog++;
        prev_io   = io_clk;
        half_prev = half_last;
        half_last = half;
    endtask

    task automatic run_until_idle(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (act && cnt < budget);
    endtask

    task automatic ticks_to_half(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!half && cnt < budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_stats();
        #1 rst_n = 1'b0;
        #11;
        check("rst_io", io_clk, 0);
        check("rst_half", half, 0);
        check("rst_qtr", qtr, 0);
        check("rst_act", act, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // h=4 q=2 free run
        clear_stats();
        en = 1'b1;
        repeat (20) tick();
        check("t1_halves", c_half, 5);
        check("t1_quarters", c_qtr, 5);
        check("t1_toggles", c_tog, 4);

        // stop mid high half-period
        tick();
        tick();
        check("t2_pre_io", io_clk, 1);
        en = 1'b0;
        clear_stats();
        run_until_idle(20, n);
        check("t2_stop_cycles", n, 3);
        check("t2_halves", c_half, 1);
        check("t2_half_then_fall", half_prev, 1);
        check("t2_park_io", io_clk, 0);

        // idle=1 h=3 one-cycle enable
        idl = 1'b1;
        ht  = 16'd3;
        qt  = 16'd1;
        tick();
        tick();
        check("t3_idle_io", io_clk, 1);
        clear_stats();
        en = 1'b1;
        tick();
        en = 1'b0;
        run_until_idle(20, n);
        check("t3_cycles", n, 6);
        check("t3_active", c_act, 6);
        check("t3_halves", c_half, 2);
        check("t3_park_io", io_clk, 1);

        // target change mid half-period
        idl = 1'b0;
        ht  = 16'd4;
        qt  = 16'd2;
        tick();
        tick();
        en = 1'b1;
        repeat (3) tick();
        ht = 16'd6;
        ticks_to_half(20, n);
        check("t4_cur_half", n, 1);
        ticks_to_half(20, n);
        check("t4_next_half", n, 6);
        ticks_to_half(20, n);
        check("t4_third_half", n, 6);
        en = 1'b0;
        run_until_idle(40, n);
        check("t4_idle", act, 0);

        // quarter beyond half is suppressed
        ht = 16'd4;
        qt = 16'd5;
        tick();
        tick();
        clear_stats();
        en = 1'b1;
        repeat (16) tick();
        check("t5_quarters", c_qtr, 0);
        check("t5_halves", c_half, 4);
        en = 1'b0;
        run_until_idle(40, n);

        // h=0 acts as h=1
        ht = 16'd0;
        qt = 16'd0;
        tick();
        tick();
        clear_stats();
        prev_io = io_clk;
        en = 1'b1;
        repeat (6) tick();
        check("t6_halves", c_half, 6);
        check("t6_toggles", c_tog, 5);
        en = 1'b0;
        run_until_idle(10, n);
        check("t6_idle", act, 0);

        // async reset mid-run then restart
        ht = 16'd4;
        qt = 16'd2;
        tick();
        tick();
        en = 1'b1;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("r_io", io_clk, 0);
        check("r_half", half, 0);
        check("r_qtr", qtr, 0);
        check("r_act", act, 0);
        model_reset();
        tick();
        tick();
        #3 rst_n = 1'b1;
        ticks_to_half(10, n);
        check("r_first_half", n, 4);
        en = 1'b0;
        run_until_idle(20, n);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
